// File: rtl/hazard_ctrl_if.sv
// Decoder/datapath <-> hazard unit bundle: D-stage class bits and register fields in,
// stall, forwarding selects, stage write addresses and stall counter out.
interface hazard_ctrl_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    logic             cls_j;
    logic             cls_r;
    logic             cls_i;
    logic             cls_ld;
    logic             cls_st;
    logic             cls_jal;
    logic [AW-1:0]    rs_d;
    logic [AW-1:0]    rt_d;
    logic [AW-1:0]    rd_d;
    logic             stall;
    logic [1:0]       fwd_rs_d;
    logic [1:0]       fwd_rt_d;
    logic [1:0]       fwd_rs_e;
    logic [1:0]       fwd_rt_e;
    logic             fwd_rt_m;
    logic [AW-1:0]    a3_e;
    logic [AW-1:0]    a3_m;
    logic [AW-1:0]    a3_w;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output cls_j, cls_r, cls_i, cls_ld, cls_st, cls_jal, rs_d, rt_d, rd_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
        input  a3_e, a3_m, a3_w, stall_cnt
    );

    modport slave (
        input  cls_j, cls_r, cls_i, cls_ld, cls_st, cls_jal, rs_d, rt_d, rd_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
        output a3_e, a3_m, a3_w, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard unit: Tuse/Tnew stall detection, E/M/W scoreboard shift register
// and nearest-producer forwarding select generation.
module hazard_ctrl #(
    parameter int AW    = 5,
    parameter int TW    = 2,
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    hazard_ctrl_if.slave hz
);

    logic [AW-1:0]    a3_dec;
    logic [TW-1:0]    tnew_dec;
    logic             use_rs;
    logic             use_rt;
    logic [TW-1:0]    tuse_rs;
    logic [TW-1:0]    tuse_rt;
    logic             stall_now;

    // Stages keep only the fields some later comparison reads.
    logic [AW-1:0]    a3_e_reg, rs_e_reg, rt_e_reg;
    logic [TW-1:0]    tnew_e_reg;
    logic [AW-1:0]    a3_m_reg, rt_m_reg;
    logic [TW-1:0]    tnew_m_reg;
    logic [AW-1:0]    a3_w_reg;
    logic [TW-1:0]    tnew_w_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    function automatic logic [TW-1:0] tnew_dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    function automatic logic src_hazard(
        input logic [AW-1:0] src, input logic en, input logic [TW-1:0] tuse,
        input logic [AW-1:0] a3_n, input logic [TW-1:0] tnew_n,
        input logic [AW-1:0] a3_f, input logic [TW-1:0] tnew_f
    );
        logic h;
        h = 1'b0;
        if (en && src != '0) begin
            if (a3_n == src)      h = (tnew_n > tuse);
            else if (a3_f == src) h = (tnew_f > tuse);
        end
        return h;
    endfunction

    // Nearest matching stage decides; a match still producing leaves the select at 0.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] a3_n, input logic [TW-1:0] tnew_n, input logic [1:0] sel_n,
        input logic [AW-1:0] a3_f, input logic [TW-1:0] tnew_f, input logic [1:0] sel_f
    );
        logic [1:0] s;
        s = 2'd0;
        if (src != '0) begin
            if (a3_n == src)      s = (tnew_n == '0) ? sel_n : 2'd0;
            else if (a3_f == src) s = (tnew_f == '0) ? sel_f : 2'd0;
        end
        return s;
    endfunction

    always_comb begin
        a3_dec   = '0;
        tnew_dec = '0;
        if (hz.cls_ld) begin
            a3_dec   = hz.rt_d;
            tnew_dec = TW'(2);
        end else if (hz.cls_r) begin
            a3_dec   = hz.rd_d;
            tnew_dec = TW'(1);
        end else if (hz.cls_i) begin
            a3_dec   = hz.rt_d;
            tnew_dec = TW'(1);
        end else if (hz.cls_jal) begin
            a3_dec   = AW'(31);
            tnew_dec = '0;
        end
    end

    always_comb begin
        use_rs  = hz.cls_j | hz.cls_r | hz.cls_i | hz.cls_ld | hz.cls_st;
        tuse_rs = hz.cls_j ? TW'(0) : TW'(1);
        use_rt  = hz.cls_j | hz.cls_r | hz.cls_st;
        tuse_rt = hz.cls_j ? TW'(0) : (hz.cls_r ? TW'(1) : TW'(2));
    end

    assign stall_now =
        src_hazard(hz.rs_d, use_rs, tuse_rs, a3_e_reg, tnew_e_reg, a3_m_reg, tnew_m_reg) |
        src_hazard(hz.rt_d, use_rt, tuse_rt, a3_e_reg, tnew_e_reg, a3_m_reg, tnew_m_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a3_e_reg      <= '0;
            rs_e_reg      <= '0;
            rt_e_reg      <= '0;
            tnew_e_reg    <= '0;
            a3_m_reg      <= '0;
            rt_m_reg      <= '0;
            tnew_m_reg    <= '0;
            a3_w_reg      <= '0;
            tnew_w_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (stall_now) begin
                a3_e_reg   <= '0;
                rs_e_reg   <= '0;
                rt_e_reg   <= '0;
                tnew_e_reg <= '0;
            end else begin
                a3_e_reg   <= a3_dec;
                rs_e_reg   <= hz.rs_d;
                rt_e_reg   <= hz.rt_d;
                tnew_e_reg <= tnew_dec;
            end
            a3_m_reg      <= a3_e_reg;
            rt_m_reg      <= rt_e_reg;
            tnew_m_reg    <= tnew_dec_sat(tnew_e_reg);
            a3_w_reg      <= a3_m_reg;
            tnew_w_reg    <= tnew_dec_sat(tnew_m_reg);
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(stall_now);
        end
    end

    assign hz.stall     = stall_now;
    assign hz.fwd_rs_d  = fwd_sel(hz.rs_d, a3_e_reg, tnew_e_reg, 2'd1, a3_m_reg, tnew_m_reg, 2'd2);
    assign hz.fwd_rt_d  = fwd_sel(hz.rt_d, a3_e_reg, tnew_e_reg, 2'd1, a3_m_reg, tnew_m_reg, 2'd2);
    assign hz.fwd_rs_e  = fwd_sel(rs_e_reg, a3_m_reg, tnew_m_reg, 2'd1, a3_w_reg, tnew_w_reg, 2'd2);
    assign hz.fwd_rt_e  = fwd_sel(rt_e_reg, a3_m_reg, tnew_m_reg, 2'd1, a3_w_reg, tnew_w_reg, 2'd2);
    assign hz.fwd_rt_m  = (rt_m_reg != '0) && (a3_w_reg == rt_m_reg) && (tnew_w_reg == '0);
    assign hz.a3_e      = a3_e_reg;
    assign hz.a3_m      = a3_m_reg;
    assign hz.a3_w      = a3_w_reg;
    assign hz.stall_cnt = stall_cnt_reg;

endmodule
